// File: rtl/conv_encoder.sv
// ============================================================================
//  Module      : conv_encoder
//  Description : Rate-1/2, K=3 convolutional encoder (G0=7, G1=5 octal) with
//                framed input, two zero tail bits per frame, valid/ready I/O.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_encoder #(
    parameter int FRAME_LEN = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       valid_i,
    input  logic       data_bit_i,
    output logic       ready_o,
    output logic [1:0] sym_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       sof_o,
    output logic       eof_o,
    output logic [1:0] state_o
);

    localparam int               CNT_W  = $clog2(FRAME_LEN) + 1;
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);

    typedef enum logic [0:0] {
        ST_DATA = 1'b0,
        ST_TAIL = 1'b1
    } fsm_t;

    fsm_t             r_fsm;
    fsm_t             w_fsm_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [1:0]       r_enc;
    logic [1:0]       r_sym;
    logic             r_valid;
    logic             r_sof;
    logic             r_eof;

    logic             w_free;
    logic             w_load;
    logic             w_u;
    logic             w_sof;
    logic             w_eof;
    logic             w_ready;
    logic [1:0]       w_sym;

    assign w_free  = !r_valid || ready_i;
    assign w_sym   = {w_u ^ r_enc[1] ^ r_enc[0], w_u ^ r_enc[0]};

    assign ready_o = w_ready;
    assign sym_o   = r_sym;
    assign valid_o = r_valid;
    assign sof_o   = r_sof;
    assign eof_o   = r_eof;
    assign state_o = r_enc;

    // The bit counter doubles as the tail index (0 then 1) while in TAIL.
    always_comb begin
        w_fsm_nxt = r_fsm;
        w_cnt_nxt = r_cnt;
        w_ready   = 1'b0;
        w_load    = 1'b0;
        w_u       = 1'b0;
        w_sof     = 1'b0;
        w_eof     = 1'b0;
        case (r_fsm)
            ST_DATA: begin
                w_ready = w_free;
                if (valid_i && w_free) begin
                    w_load = 1'b1;
                    w_u    = data_bit_i;
                    w_sof  = (r_cnt == '0);
                    if (r_cnt == c_LAST) begin
                        w_cnt_nxt = '0;
                        w_fsm_nxt = ST_TAIL;
                    end else begin
                        w_cnt_nxt = r_cnt + c_ONE;
                    end
                end
            end
            ST_TAIL: begin
                if (w_free) begin
                    w_load = 1'b1;
                    if (r_cnt == c_ONE) begin
                        w_eof     = 1'b1;
                        w_cnt_nxt = '0;
                        w_fsm_nxt = ST_DATA;
                    end else begin
                        w_cnt_nxt = r_cnt + c_ONE;
                    end
                end
            end
            default: begin
                w_fsm_nxt = ST_DATA;
                w_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm <= ST_DATA;
            r_cnt <= '0;
        end else begin
            r_fsm <= w_fsm_nxt;
            r_cnt <= w_cnt_nxt;
        end
    end

    // Output slot: loads overwrite even while a consume happens this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_sym   <= 2'b00;
            r_sof   <= 1'b0;
            r_eof   <= 1'b0;
            r_enc   <= 2'b00;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_sym   <= w_sym;
            r_sof   <= w_sof;
            r_eof   <= w_eof;
            r_enc   <= {w_u, r_enc[1]};
        end else if (ready_i) begin
            r_valid <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_conv_encoder.sv
// ============================================================================
//  Module      : tb_conv_encoder
//  Description : Scoreboard bench for conv_encoder with FRAME_LEN = 4.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_conv_encoder;

    localparam int FL = 4;

    logic       clk;
    logic       rst_n;
    logic       valid_i;
    logic       data_bit_i;
    logic       ready_o;
    logic [1:0] sym_o;
    logic       valid_o;
    logic       ready_i;
    logic       sof_o;
    logic       eof_o;
    logic [1:0] state_o;

    conv_encoder #(.FRAME_LEN(FL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_i    (valid_i),
        .data_bit_i (data_bit_i),
        .ready_o    (ready_o),
        .sym_o      (sym_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .sof_o      (sof_o),
        .eof_o      (eof_o),
        .state_o    (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_sof  = 0;
    int n_eof  = 0;
    bit mon_en = 1'b1;

    // expected entries: {sof, eof, sym[1:0]}
    logic [3:0] q[$];
    logic [1:0] m_state;
    int         m_cnt;

    task automatic model_reset();
        m_state = 2'b00;
        m_cnt   = 0;
    endtask

    task automatic model_bit(input logic u);
        logic [1:0] g;
        g = {u ^ m_state[1] ^ m_state[0], u ^ m_state[0]};
        q.push_back({(m_cnt == 0), 1'b0, g});
        m_state = {u, m_state[1]};
        m_cnt++;
        if (m_cnt == FL) begin
            for (int t = 0; t < 2; t++) begin
                g = {m_state[1] ^ m_state[0], m_state[0]};
                q.push_back({1'b0, (t == 1), g});
                m_state = {1'b0, m_state[1]};
            end
            m_cnt = 0;
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && rst_n && valid_o && ready_i) begin
            logic [3:0] e;
            checks++;
            n_sof += int'(sof_o);
            n_eof += int'(eof_o);
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_symbol: got sof=%0b eof=%0b sym=%b, required none", sof_o, eof_o, sym_o);
            end else begin
                e = q.pop_front();
                if ({sof_o, eof_o, sym_o} !== e) begin
                    errors++;
                    $display("FAIL symbol: got sof=%0b eof=%0b sym=%b, required sof=%0b eof=%0b sym=%b",
                             sof_o, eof_o, sym_o, e[3], e[2], e[1:0]);
                end
            end
        end
    end

    // Offers bit b, returns #1 after the accepting edge with valid_i still high.
    task automatic send_bit(input logic b, input bit push);
        int n;
        if (push) model_bit(b);
        valid_i    = 1'b1;
        data_bit_i = b;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ready_o && n < 100);
        if (!ready_o) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: ready_o=%0b, required 1", ready_o);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || valid_o) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q.size() != 0 || valid_o) begin
            errors++;
            $display("FAIL drain: pending=%0d valid_o=%0b, required 0 and 0", q.size(), valid_o);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            valid_i    = 1'($urandom_range(0, 1));
            data_bit_i = 1'($urandom_range(0, 1));
            @(negedge clk);
            checks++;
            if ({valid_o, sym_o, sof_o, eof_o, state_o, ready_o} !== 8'b0_00_0_0_00_1) begin
                errors++;
                $display("FAIL reset_state: got valid=%0b sym=%b sof=%0b eof=%0b state=%b ready=%0b, required 0 00 0 0 00 1",
                         valid_o, sym_o, sof_o, eof_o, state_o, ready_o);
            end
        end
        valid_i = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_known();
        int low;
        q.push_back(4'b1_0_11);
        q.push_back(4'b0_0_10);
        q.push_back(4'b0_0_00);
        q.push_back(4'b0_0_01);
        q.push_back(4'b0_0_01);
        q.push_back(4'b0_1_11);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        valid_i = 1'b0;
        low = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!ready_o) low++;
        end
        checks++;
        if (low != 2) begin
            errors++;
            $display("FAIL known_ready_low: got %0d cycles, required 2", low);
        end
        drain();
        checks++;
        if (state_o !== 2'b00) begin
            errors++;
            $display("FAIL known_end_state: got %b, required 00", state_o);
        end
    endtask

    task automatic test_impulse();
        q.push_back(4'b1_0_11);
        q.push_back(4'b0_0_10);
        q.push_back(4'b0_0_11);
        q.push_back(4'b0_0_00);
        q.push_back(4'b0_0_00);
        q.push_back(4'b0_1_00);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        valid_i = 1'b0;
        drain();
    endtask

    task automatic test_backpressure();
        model_reset();
        ready_i = 1'b1;
        send_bit(1'b1, 1'b1);
        ready_i    = 1'b0;
        valid_i    = 1'b1;
        data_bit_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({valid_o, sym_o, ready_o, state_o} !== 6'b1_11_0_10) begin
                errors++;
                $display("FAIL backpressure_hold: got valid=%0b sym=%b ready=%0b state=%b, required 1 11 0 10",
                         valid_o, sym_o, ready_o, state_o);
            end
        end
        @(posedge clk);
        #1;
        ready_i = 1'b1;
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b1);
        valid_i = 1'b0;
        drain();
    endtask

    task automatic test_back_to_back();
        int sof0;
        int eof0;
        int run;
        int n;
        model_reset();
        ready_i = 1'b1;
        sof0    = n_sof;
        eof0    = n_eof;
        run     = 0;
        fork
            begin
                for (int i = 0; i < 3 * FL; i++) send_bit(1'($urandom_range(0, 1)), 1'b1);
                valid_i = 1'b0;
            end
            begin
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!valid_o && n < 50);
                for (int i = 0; i < 3 * (FL + 2); i++) begin
                    if (i > 0) @(negedge clk);
                    if (valid_o) run++;
                end
            end
        join
        drain();
        checks++;
        if (run != 3 * (FL + 2)) begin
            errors++;
            $display("FAIL b2b_no_bubble: got %0d valid cycles, required %0d", run, 3 * (FL + 2));
        end
        checks++;
        if (n_sof - sof0 != 3 || n_eof - eof0 != 3) begin
            errors++;
            $display("FAIL b2b_frame_marks: got sof=%0d eof=%0d, required 3 and 3", n_sof - sof0, n_eof - eof0);
        end
    endtask

    task automatic test_mid_reset();
        int sof0;
        ready_i = 1'b1;
        mon_en  = 1'b0;
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        valid_i = 1'b0;
        rst_n   = 1'b0;
        #1;
        checks++;
        if ({valid_o, state_o} !== 3'b0_00) begin
            errors++;
            $display("FAIL midreset_async: got valid=%0b state=%b, required 0 00", valid_o, state_o);
        end
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (valid_o !== 1'b0) begin
                errors++;
                $display("FAIL midreset_stale: got valid_o=%0b, required 0", valid_o);
            end
        end
        @(posedge clk);
        #1;
        model_reset();
        sof0 = n_sof;
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b1);
        valid_i = 1'b0;
        drain();
        checks++;
        if (n_sof - sof0 != 1) begin
            errors++;
            $display("FAIL midreset_sof: got %0d, required 1", n_sof - sof0);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        valid_i    = 1'b0;
        data_bit_i = 1'b0;
        ready_i    = 1'b1;
        model_reset();
        test_reset();
        test_known();
        test_impulse();
        test_backpressure();
        test_back_to_back();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/conv_encoder.md
# conv_encoder

Rate-1/2, constraint-length-3 convolutional encoder. It is the transmit-side counterpart of the 4-state Viterbi decoder (branch metric, ACS and TBU). It accepts a stream of information bits in fixed-length frames and emits one 2-bit code symbol per input bit. After each frame it appends K-1 = 2 zero tail bits, so the trellis returns to state S0 at the frame boundary, where the decoder expects it. It has valid/ready handshakes on both sides and a single registered output stage.

## Interface
- FRAME_LEN, 32: information bits per frame; legal range ≥ 1.
- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- valid_i  in  1  upstream offers data_bit_i.
- data_bit_i  in  1  information bit u.
- ready_o  out  1  encoder accepts data_bit_i this cycle.
- sym_o  out  2  code symbol; sym_o[1] = G0 output (octal 7), sym_o[0] = G1 output (octal 5).
- valid_o  out  1  sym_o is valid.
- ready_i  in  1  downstream consumes sym_o this cycle.
- sof_o  out  1  sym_o is the first symbol of a frame.
- eof_o  out  1  sym_o is the last symbol of a frame (second tail symbol).
- state_o  out  2  current encoder state {u[n-1], u[n-2]}, for debug and bench checking.

## Operation
- Encoder state s = {s[1], s[0]} = {u[n-1], u[n-2]}. State numbering matches the decoder: S2 = 2'b10 is reached from S0 with input 1.
- Per encoded bit u: G0 = u ^ s[1] ^ s[0], G1 = u ^ s[0], next state = {u, s[1]}.
- The FSM has two states: DATA and TAIL. The bit counter is $clog2(FRAME_LEN)+1 bits wide.
- Output slot free: free = !valid_o || ready_i.
- DATA state:
  - ready_o = free.
  - Accept when valid_i && ready_o: encode data_bit_i, load the output register, increment the counter.
  - sof_o = 1 when the counter was 0 at acceptance.
  - When the accepted bit is number FRAME_LEN-1: clear the counter and go to TAIL.
- TAIL state:
  - ready_o = 0; valid_i is ignored.
  - On each cycle with free = 1, encode an internal u = 0 and load the output register. Two tail symbols are produced.
  - The second tail symbol sets eof_o = 1 and returns the FSM to DATA. state_o is 2'b00 at that point.
- Output register:
  - sym_o, sof_o and eof_o change only when a new symbol is loaded.
  - If the slot is full and ready_i = 0, all outputs hold stable.
  - valid_o clears when ready_i = 1 and no new symbol loads in the same cycle.
- Each frame produces exactly FRAME_LEN+2 symbols. Frames are back to back; the first data bit of the next frame can be accepted in the same cycle the eof symbol is consumed.
- FRAME_LEN = 1: the single data symbol carries sof_o = 1. The frame is then the two tail symbols, with eof_o on the last one.

## Timing
- Reset values (rst_n low): valid_o = 0, sym_o = 2'b00, sof_o = 0, eof_o = 0, state_o = 2'b00, FSM = DATA, counter = 0. ready_o reads 1, since it is derived from the reset state.
- Latency: a bit accepted at edge n is on sym_o with valid_o = 1 after edge n. There is one register stage.
- Throughput: one symbol per cycle when ready_i is held at 1. The two tail cycles insert 2 cycles with ready_o = 0 per frame.
- ready_o depends combinationally on ready_i. No other input-to-output combinational path exists.
- Simultaneous consume and load (valid_o = 1, ready_i = 1, new symbol): valid_o stays 1 and sym_o takes the new value.
- Reset asserted mid-frame: the frame is discarded, outputs return to reset values immediately, and the next accepted bit starts a new frame with sof_o = 1.
- Backpressure during TAIL: tail symbols wait; the FSM stays in TAIL until both tail symbols are loaded.

## Test plan
- Reset: hold rst_n = 0 with random valid_i and data_bit_i -> valid_o = 0, sym_o = 00, state_o = 00, ready_o = 1. Release reset -> first accepted bit has sof_o = 1.
- Known vector (FRAME_LEN = 4, ready_i = 1, input 1,0,1,1):
  - Symbols are 11, 10, 00, 01, then tail 01, 11.
  - sof_o on the first symbol, eof_o on the last.
  - state_o ends at 00.
  - ready_o = 0 for exactly 2 cycles.
- Impulse (FRAME_LEN = 4, input 1,0,0,0) -> symbols 11, 10, 11, 00, 00, 00.
- Backpressure: after the first symbol, hold ready_i = 0 for 5 cycles with valid_i = 1 -> sym_o stays 11, valid_o = 1, ready_o = 0, no bit consumed. Release -> the sequence continues unchanged.
- Back-to-back frames (FRAME_LEN = 4, valid_i and ready_i held at 1 for 3 frames):
  - 18 symbols total.
  - sof_o at symbol indices 0, 6, 12; eof_o at 5, 11, 17.
  - No bubble at the eof-to-sof transition.
- Mid-frame reset: pulse rst_n low after 2 accepted bits -> no further symbols from the old frame. The next bit produces sof_o = 1, and its symbol is computed from state 00.
